bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_controller_pkg.sv | 23 ++
 rtl/bist_pattern_counter.sv | 27 ++
 rtl/bist_controller.sv | 131 +++++++++++++
 tb/tb_bist_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_controller_pkg.sv
// Shared definitions for the BIST controller: FSM state encodings, default sizing
// and the pattern-counter width.
package bist_controller_pkg;

    localparam int DEFAULT_NUM_PATTERNS = 15;
    localparam int DEFAULT_SIG_W        = 4;
    localparam int CNT_W                = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Terminal count of the pattern counter for a run of num_patterns cycles.
    function automatic logic [CNT_W-1:0] last_count(input int num_patterns);
        return CNT_W'(num_patterns - 1);
    endfunction

endpackage

// File: rtl/bist_pattern_counter.sv
// Pattern counter for the BIST RUN phase: synchronous clear, count enable and a
// terminal-count flag that goes high on the last pattern of the run.
module bist_pattern_counter
    import bist_controller_pkg::*;
#(
    parameter logic [CNT_W-1:0] LAST = 8'd14
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == LAST);

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: clears TPG/ORA, runs NUM_PATTERNS patterns, flushes the ORA
// pipeline, compares the MISR signature with GOLDEN_SIG and holds the result.
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int               NUM_PATTERNS = DEFAULT_NUM_PATTERNS,
    parameter int               SIG_W        = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = SIG_W'(4'hA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             tpg_rst,
    output logic             tpg_en,
    output logic             ora_rst,
    output logic             ora_en,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] LAST_COUNT = last_count(NUM_PATTERNS);

    state_t r_state;
    logic   r_start_q;
    logic   r_init;
    logic   r_tpg_en;
    logic   r_ora_en;
    logic   r_busy;
    logic   r_done;
    logic   r_pass;

    logic   w_launch;
    logic   w_cnt_clr;
    logic   w_cnt_en;
    logic   w_tc;

    assign w_launch  = start & ~r_start_q;
    assign w_cnt_clr = (r_state == ST_INIT);
    assign w_cnt_en  = (r_state == ST_RUN);

    bist_pattern_counter #(
        .LAST (LAST_COUNT)
    ) u_pattern_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // Outputs are registered alongside the state so each one is valid for the
    // whole cycle of the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_init    <= 1'b0;
            r_tpg_en  <= 1'b0;
            r_ora_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_start_q <= start;
            r_ora_en  <= r_tpg_en;
            if (abort) begin
                r_state  <= ST_IDLE;
                r_init   <= 1'b0;
                r_tpg_en <= 1'b0;
                r_ora_en <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_pass   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_launch) begin
                            r_state <= ST_INIT;
                            r_init  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                    ST_INIT: begin
                        r_state  <= ST_RUN;
                        r_init   <= 1'b0;
                        r_tpg_en <= 1'b1;
                    end
                    ST_RUN: begin
                        if (w_tc) begin
                            r_state  <= ST_FLUSH;
                            r_tpg_en <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        r_state <= ST_COMPARE;
                    end
                    ST_COMPARE: begin
                        r_state <= ST_DONE;
                        r_pass  <= (misr_sig == GOLDEN_SIG);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_init   <= 1'b0;
                        r_tpg_en <= 1'b0;
                        r_ora_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Reset also drives the datapath clears so TPG and ORA stay cleared while rst is held.
    assign tpg_rst = rst | r_init;
    assign ora_rst = rst | r_init;
    assign tpg_en  = r_tpg_en;
    assign ora_en  = r_ora_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: a 15-pattern and a 1-pattern instance checked every
// cycle against a launch-relative timeline model of the BIST run.
module tb_bist_controller;

    localparam int         N0   = 15;
    localparam int         N1   = 1;
    localparam logic [3:0] GOLD = 4'hA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] abort = 2'b00;
    logic [3:0] misr [2];
    logic [1:0] tpg_rst, tpg_en, ora_rst, ora_en, busy, done, pass;

    always #5 clk = ~clk;

    bist_controller #(.NUM_PATTERNS(N0), .SIG_W(4), .GOLDEN_SIG(GOLD)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .misr_sig(misr[0]),
        .tpg_rst(tpg_rst[0]), .tpg_en(tpg_en[0]), .ora_rst(ora_rst[0]), .ora_en(ora_en[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0])
    );

    bist_controller #(.NUM_PATTERNS(N1), .SIG_W(4), .GOLDEN_SIG(GOLD)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .misr_sig(misr[1]),
        .tpg_rst(tpg_rst[1]), .tpg_en(tpg_en[1]), .ora_rst(ora_rst[1]), .ora_en(ora_en[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1])
    );

    // Model: m_t is the current cycle index relative to the launch cycle (0).
    int m_n [2] = '{N0, N1};
    bit m_active [2];
    int m_t [2];
    bit m_done [2];
    bit m_pass [2];
    bit m_prev [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    function automatic logic [6:0] exp_vec(input int d);
        logic a;
        int   t;
        int   n;
        a = m_active[d];
        t = m_t[d];
        n = m_n[d];
        return {rst | (a && t == 1),
                a && t >= 2 && t <= n + 1,
                rst | (a && t == 1),
                a && t >= 3 && t <= n + 2,
                a, m_done[d], m_pass[d]};
    endfunction

    function automatic logic [6:0] obs_vec(input int d);
        return {tpg_rst[d], tpg_en[d], ora_rst[d], ora_en[d], busy[d], done[d], pass[d]};
    endfunction

    task automatic tick();
        bit launch;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_active[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_prev[d] = 0; m_t[d] = 0;
            end else begin
                launch    = start[d] && !m_prev[d];
                m_prev[d] = start[d];
                if (abort[d]) begin
                    m_active[d] = 0; m_done[d] = 0; m_pass[d] = 0;
                end else if (m_active[d]) begin
                    if (m_t[d] == m_n[d] + 3) begin
                        m_pass[d]   = (misr[d] == GOLD);
                        m_done[d]   = 1;
                        m_active[d] = 0;
                    end else begin
                        m_t[d]++;
                    end
                end else if (launch) begin
                    m_active[d] = 1; m_t[d] = 1; m_done[d] = 0; m_pass[d] = 0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    function automatic logic [3:0] bad_sig();
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        if (v == GOLD) v = v ^ 4'h1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== 7'b1010000) begin
                    miscompares++;
                    $display("FAIL reset_hold dut%0d cycle %0d: got %b expected %b", d, cyc, obs_vec(d), 7'b1010000);
                end
            end
        end
        rst = 1'b0;
        repeat (2) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== 7'b0000000) begin
                    miscompares++;
                    $display("FAIL reset_release dut%0d cycle %0d: got %b expected %b", d, cyc, obs_vec(d), 7'b0000000);
                end
            end
        end
    endtask

    task automatic test_golden_run();
        int ten_cnt = 0;
        int first_done = -1;
        misr[0] = GOLD;
        start[0] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            start[0] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL golden_run dut%0d rel %0d: got %b expected %b", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (tpg_en[0]) ten_cnt++;
            if (done[0] && first_done < 0) first_done = k;
        end
        vectors++;
        if (ten_cnt !== 15) begin
            miscompares++;
            $display("FAIL golden_tpg_en_len: got %0d expected %0d", ten_cnt, 15);
        end
        vectors++;
        if (first_done !== 19 || pass[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL golden_done_pass: done at %0d pass %b, expected 19 and 1", first_done, pass[0]);
        end
    endtask

    task automatic test_bad_sig();
        int first_done = -1;
        logic pass_at = 1'b1;
        misr[0] = bad_sig();
        start[0] = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            start[0] = 1'b0;
            misr[0] = bad_sig();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL bad_sig dut%0d rel %0d: got %b expected %b", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (done[0] && first_done < 0) begin
                first_done = k;
                pass_at = pass[0];
            end
        end
        vectors++;
        if (first_done !== 19 || pass_at !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_sig_result: done at %0d pass %b, expected 19 and 0", first_done, pass_at);
        end
    endtask

    task automatic test_abort();
        int ten_cnt = 0;
        misr[0] = GOLD;
        start[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            start[0] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL abort_pre dut%0d rel %0d: got %b expected %b", d, k, obs_vec(d), exp_vec(d));
                end
            end
        end
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        vectors++;
        if ({tpg_en[0], ora_en[0], busy[0], done[0], pass[0]} !== 5'b00000) begin
            miscompares++;
            $display("FAIL abort_idle: got %b expected 00000", {tpg_en[0], ora_en[0], busy[0], done[0], pass[0]});
        end
        tick();
        start[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start[0] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL abort_rerun dut%0d rel %0d: got %b expected %b", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (tpg_en[0]) ten_cnt++;
        end
        vectors++;
        if (ten_cnt !== 15 || done[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_rerun_len: tpg_en %0d done %b, expected 15 and 1", ten_cnt, done[0]);
        end
    endtask

    task automatic test_start_held();
        int runs = 0;
        logic prev_busy = 1'b0;
        misr[0] = GOLD;
        start[0] = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            tick();
            if (k == 40) start[0] = 1'b0;
            if (k == 42) start[0] = 1'b1;
            if (k == 43) start[0] = 1'b0;
            if (k == 48) start[0] = 1'b1;
            if (k == 49) start[0] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL start_held dut%0d rel %0d: got %b expected %b", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (busy[0] && !prev_busy) runs++;
            prev_busy = busy[0];
            if (k == 40) begin
                vectors++;
                if (runs !== 1) begin
                    miscompares++;
                    $display("FAIL start_held_runs: got %0d expected 1", runs);
                end
            end
        end
        vectors++;
        if (runs !== 2 || done[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_pulse_ignored: runs %0d done %b, expected 2 and 1", runs, done[0]);
        end
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        vectors++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1 || pass[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL done_restart: done %b busy %b pass %b, expected 0 1 0", done[0], busy[0], pass[0]);
        end
        repeat (20) tick();
    endtask

    task automatic test_single_pattern();
        int ten_cnt = 0;
        int first_done = -1;
        misr[1] = GOLD;
        start[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            start[1] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL single_pattern dut%0d rel %0d: got %b expected %b", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (tpg_en[1]) ten_cnt++;
            if (done[1] && first_done < 0) first_done = k;
        end
        vectors++;
        if (ten_cnt !== 1 || first_done !== 5 || pass[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pattern_timing: tpg_en %0d done at %0d pass %b, expected 1 5 1", ten_cnt, first_done, pass[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int d = 0; d < 2; d++) begin
                start[d] = ($urandom_range(0, 3) == 0);
                abort[d] = ($urandom_range(0, 59) == 0);
                misr[d]  = ($urandom_range(0, 1) == 0) ? GOLD : 4'($urandom_range(0, 15));
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cycle %0d: got %b expected %b", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        rst = 1'b0;
        start = 2'b00;
        abort = 2'b00;
    endtask

    initial begin
        misr[0] = 4'h0;
        misr[1] = 4'h0;
        test_reset();
        test_golden_run();
        tick();
        test_bad_sig();
        tick();
        test_abort();
        tick();
        test_start_held();
        test_single_pattern();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
